// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory model: data width, byte-lane
// mask widths, read FSM state encoding and the default memory base address.
package lsu_pkg;

    localparam int XLEN      = 32;
    localparam int MASK_W    = 8;
    localparam int MASK_USED = 4;

    localparam logic [XLEN-1:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    // Read FSM: waiting for a request, or counting down an accepted read
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_rd_state_e;

endpackage

// File: rtl/lsu_sram_lfsr.sv
// Read-delay generator for the LSU data SRAM: an 8-bit Galois LFSR with
// polynomial x^8+x^6+x^5+x^4+1, reseeded to 8'h5A on reset and stepped
// every clock. Only instantiated when LSU_SRAM_RAND_DELAY_EN is defined.
module lsu_sram_lfsr (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [7:0] o_lfsr
);

    localparam logic [7:0] SEED = 8'h5A;
    localparam logic [7:0] TAPS = 8'hB8;

    logic [7:0] r_state;

    // Right-shifting Galois step: feedback from bit 0 folds into the tap positions
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SEED;
        end else if (r_state[0]) begin
            r_state <= (r_state >> 1) ^ TAPS;
        end else begin
            r_state <= r_state >> 1;
        end
    end

    assign o_lfsr = r_state;

endmodule

// File: rtl/lsu_data_sram.sv
// Word-organised data SRAM behind the load/store unit. Writes are byte-lane
// masked and complete on the edge they are presented; reads are accepted by a
// two-state FSM and return the whole aligned word after a fixed latency.
// Optional feature macro: LSU_SRAM_RAND_DELAY_EN adds 0..7 extra read cycles
// taken from an LFSR.
module lsu_data_sram
    import lsu_pkg::*;
#(
    parameter int               DEPTH     = 65536,
    parameter logic [XLEN-1:0]  BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int               READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   raddr,
    input  logic [XLEN-1:0]   waddr,
    input  logic [MASK_W-1:0] wmask,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic              rvalid
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(READ_LAT + 8);

    logic [XLEN-1:0]  r_mem [DEPTH];
    lsu_rd_state_e    r_state;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_capIdx;
    logic [XLEN-1:0]  r_rdata;
    logic             r_rvalid;

    logic [XLEN-1:0]  w_rdOffset;
    logic [XLEN-1:0]  w_wrOffset;
    logic [IDX_W-1:0] w_rdIdx;
    logic [IDX_W-1:0] w_wrIdx;
    logic [CNT_W-1:0] w_loadCount;
    logic             w_unusedBits;

    // Out-of-range addresses wrap: only the low index bits of the word offset are kept
    assign w_rdOffset = raddr - BASE_ADDR;
    assign w_wrOffset = waddr - BASE_ADDR;
    assign w_rdIdx    = w_rdOffset[IDX_W+1:2];
    assign w_wrIdx    = w_wrOffset[IDX_W+1:2];

`ifdef LSU_SRAM_RAND_DELAY_EN
    logic [7:0] w_lfsr;

    lsu_sram_lfsr u_lfsr (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_lfsr (w_lfsr)
    );

    assign w_loadCount  = CNT_W'(READ_LAT - 1) + CNT_W'(w_lfsr[2:0]);
    assign w_unusedBits = ^{w_rdOffset[XLEN-1:IDX_W+2], w_rdOffset[1:0],
                            w_wrOffset[XLEN-1:IDX_W+2], w_wrOffset[1:0],
                            wmask[MASK_W-1:MASK_USED], w_lfsr[7:3]};
`else
    assign w_loadCount  = CNT_W'(READ_LAT - 1);
    assign w_unusedBits = ^{w_rdOffset[XLEN-1:IDX_W+2], w_rdOffset[1:0],
                            w_wrOffset[XLEN-1:IDX_W+2], w_wrOffset[1:0],
                            wmask[MASK_W-1:MASK_USED]};
`endif

    // Byte-lane writes; the array is deliberately untouched by reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < MASK_USED; i++) begin
            if (w_en && wmask[i]) begin
                r_mem[w_wrIdx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read FSM: capture the index, count down, then load rdata (read-first) and pulse rvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_capIdx <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_en) begin
                        r_capIdx <= w_rdIdx;
                        r_count  <= w_loadCount;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_count == '0) begin
                        r_rdata  <= r_mem[r_capIdx];
                        r_rvalid <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_lsu_data_sram.sv
// Self-checking bench for lsu_data_sram. Two instances share every input:
// one with READ_LAT=1 and one with READ_LAT=3, both with DEPTH=16 so that
// address wrap is easy to reach. A reference model tracks memory contents
// as plain words and each read as "accepted at edge N, due at edge N+LAT".
module tb_lsu_data_sram;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT0  = 1;
    localparam int          LAT1  = 3;
`ifdef LSU_SRAM_RAND_DELAY_EN
    localparam int          SLACK = 7;
`else
    localparam int          SLACK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr, waddr, wdata;
    logic [7:0]  wmask;
    logic        wEn, rEn;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] modelMem [DEPTH];
    int          lat        [2];
    bit          busy       [2];
    bit          wasBusy    [2];
    int          acceptEdge [2];
    int          capIdx     [2];
    logic [31:0] oldWord    [2];
    logic [31:0] expRdata   [2];
    int          edgeNum = 0;

    always #5 clk = ~clk;

    lsu_data_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .raddr(raddr), .waddr(waddr), .wmask(wmask),
        .w_en(wEn), .r_en(rEn), .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0)
    );

    lsu_data_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .raddr(raddr), .waddr(waddr), .wmask(wmask),
        .w_en(wEn), .r_en(rEn), .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1)
    );

    // Word index of a byte address, straight from the address map
    function automatic int wordIndex(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'((off >> 2) % DEPTH);
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Model update for one rising edge: snapshot pending read words, apply write, accept reads
    task automatic modelEdge();
        int wi;
        edgeNum++;
        for (int d = 0; d < 2; d++) begin
            wasBusy[d] = busy[d];
            oldWord[d] = modelMem[capIdx[d]];
        end
        if (wEn) begin
            wi = wordIndex(waddr);
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) modelMem[wi][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (!wasBusy[d] && rEn) begin
                busy[d]       = 1'b1;
                acceptEdge[d] = edgeNum;
                capIdx[d]     = wordIndex(raddr);
            end
        end
    endtask

    // Compare both instances against the model just after an edge
    task automatic sampleCheck();
        logic        obsValid [2];
        logic [31:0] obsData  [2];
        bit          allowed, required;
        int          elapsed;
        obsValid[0] = rvalid0; obsValid[1] = rvalid1;
        obsData[0]  = rdata0;  obsData[1]  = rdata1;
        for (int d = 0; d < 2; d++) begin
            allowed  = 1'b0;
            required = 1'b0;
            if (wasBusy[d]) begin
                elapsed  = edgeNum - acceptEdge[d];
                allowed  = (elapsed >= lat[d]) && (elapsed <= lat[d] + SLACK);
                required = (elapsed == lat[d] + SLACK);
            end
            checkOutput($sformatf("rvalid%0d@%0d", d, edgeNum), {31'b0, obsValid[d]},
                        {31'b0, (obsValid[d] ? allowed : required)});
            if (wasBusy[d] && (obsValid[d] || required)) begin
                expRdata[d] = oldWord[d];
                busy[d]     = 1'b0;
            end
            checkOutput($sformatf("rdata%0d@%0d", d, edgeNum), obsData[d], expRdata[d]);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then model and check the next rising edge
    task automatic applyStimulus(input logic re, input logic [31:0] ra, input logic we,
                                 input logic [31:0] wa, input logic [7:0] wm,
                                 input logic [31:0] wd);
        @(negedge clk);
        rEn = re; raddr = ra; wEn = we; waddr = wa; wmask = wm; wdata = wd;
        @(posedge clk);
        modelEdge();
        #1;
        sampleCheck();
    endtask

    // Assert reset between edges and confirm outputs clear without waiting for a clock
    task automatic applyReset(input string tag);
        @(negedge clk);
        rEn = 1'b0; wEn = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rdata0"}, rdata0, 32'h0);
        checkOutput({tag, "_rdata1"}, rdata1, 32'h0);
        checkOutput({tag, "_rvalid0"}, {31'b0, rvalid0}, 32'h0);
        checkOutput({tag, "_rvalid1"}, {31'b0, rvalid1}, 32'h0);
        for (int d = 0; d < 2; d++) begin
            busy[d]     = 1'b0;
            expRdata[d] = 32'h0;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Idle cycles until both instances have finished, with a bounded budget
    task automatic waitIdle(input string tag);
        for (int n = 0; n < 20 && (busy[0] || busy[1]); n++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0);
        end
        checkOutput({tag, "_idle"}, {31'b0, (busy[0] | busy[1])}, 32'h0);
    endtask

    function automatic logic [31:0] pickAddr();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return BASE + 32'($urandom_range(0, DEPTH * 8 - 1));
    endfunction

    initial begin
        lat[0] = LAT0;
        lat[1] = LAT1;
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0;
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; wasBusy[d] = 1'b0; acceptEdge[d] = 0;
            capIdx[d] = 0; oldWord[d] = 32'h0; expRdata[d] = 32'h0;
        end
        rst = 1'b1; rEn = 1'b0; wEn = 1'b0;
        raddr = 32'h0; waddr = 32'h0; wmask = 8'h00; wdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_rdata0", rdata0, 32'h0);
        checkOutput("init_rvalid0", {31'b0, rvalid0}, 32'h0);
        checkOutput("init_rdata1", rdata1, 32'h0);
        checkOutput("init_rvalid1", {31'b0, rvalid1}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0010, 8'h0F, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h8000_0013, 1'b0, 32'h0, 8'h00, 32'h0);
        waitIdle("full");
        checkOutput("full_rd0", rdata0, 32'hDEAD_BEEF);
        checkOutput("full_rd1", rdata1, 32'hDEAD_BEEF);

        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0010, 8'hF2, 32'h0000_5500);
        applyStimulus(1'b1, 32'h8000_0010, 1'b0, 32'h0, 8'h00, 32'h0);
        waitIdle("partial");
        checkOutput("partial_rd0", rdata0, 32'hDEAD_55EF);
        checkOutput("partial_rd1", rdata1, 32'hDEAD_55EF);

        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0004, 8'h0F, 32'h1234_5678);
        applyStimulus(1'b1, 32'h8000_0044, 1'b0, 32'h0, 8'h00, 32'h0);
        waitIdle("wrap");
        checkOutput("wrap_rd0", rdata0, 32'h1234_5678);
        checkOutput("wrap_rd1", rdata1, 32'h1234_5678);

        applyStimulus(1'b1, 32'h8000_0008, 1'b1, 32'h8000_0008, 8'h0F, 32'hCAFE_F00D);
        waitIdle("rdwr");
        checkOutput("rdwr_rd0", rdata0, 32'hCAFE_F00D);
        checkOutput("rdwr_rd1", rdata1, 32'hCAFE_F00D);

        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, BASE + 32'($urandom_range(0, DEPTH - 1) * 4),
                          1'b0, 32'h0, 8'h00, 32'h0);
        end
        waitIdle("busy");

        applyStimulus(1'b1, 32'h8000_0010, 1'b0, 32'h0, 8'h00, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0);
        applyReset("midrst");
        applyStimulus(1'b1, 32'h8000_0024, 1'b0, 32'h0, 8'h00, 32'h0);
        waitIdle("untouched");
        checkOutput("untouched_rd0", rdata0, 32'h0);
        checkOutput("untouched_rd1", rdata1, 32'h0);

        for (int c = 0; c < 400; c++) begin
            if (c == 200) applyReset("randrst");
            applyStimulus(($urandom_range(0, 99) < 55), pickAddr(),
                          ($urandom_range(0, 99) < 45), pickAddr(),
                          8'($urandom), $urandom);
        end
        waitIdle("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung simulation
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
